// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the sram-like bus arbiter: transaction owner id and request bundle.
`timescale 1ns/1ps
package mem_arb_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int unsigned SRAM_ADDR_W = 32;
  localparam int unsigned SRAM_DATA_W = 32;

  typedef struct packed {
    logic                   wr;
    logic [1:0]             size;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [3:0]             wstrb;
    logic                   cached;
  } sram_req_t;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_DATA) ? OWN_INST : OWN_DATA;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order FIFO of transaction owners; push on address accept, pop on data return.
`timescale 1ns/1ps
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  owner_e din,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  owner_e             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master sram-like bus arbiter with in-order response routing.
// Define ARB_RR_FAIR_EN to alternate grants under contention instead of fixed data priority.
`timescale 1ns/1ps
module sram_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_cached,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  input  logic              d_cached,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_cached,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              proto_err
);

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              cached;
  } req_t;

  req_t        i_bus;
  req_t        d_bus;
  req_t        m_bus;
  owner_e      grant;
  owner_e      lock_owner;
  owner_e      head;
  logic        lock;
  logic        owner_req;
  logic        lock_hold;
  logic        full;
  logic        empty;
  logic        accept;
  logic        pop;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
`ifdef ARB_RR_FAIR_EN
  owner_e      rr_ptr;
`endif

  assign i_bus = '{wr: i_wr, size: i_size, addr: i_addr, wdata: i_wdata, wstrb: i_wstrb, cached: i_cached};
  assign d_bus = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb, cached: d_cached};

  // A locked owner that dropped req no longer holds the grant; arbitration falls back to normal.
  assign owner_req = (lock_owner == OWN_DATA) ? d_req : i_req;
  assign lock_hold = lock & owner_req;

  always_comb begin
    grant = OWN_DATA;
    if (lock_hold) begin
      grant = lock_owner;
    end else if (d_req && i_req) begin
`ifdef ARB_RR_FAIR_EN
      grant = rr_ptr;
`else
      grant = OWN_DATA;
`endif
    end else if (!d_req && i_req) begin
      grant = OWN_INST;
    end
  end

  assign m_bus    = (grant == OWN_DATA) ? d_bus : i_bus;
  assign m_req    = (i_req | d_req) & ~full;
  assign m_wr     = m_bus.wr;
  assign m_size   = m_bus.size;
  assign m_addr   = m_bus.addr;
  assign m_wdata  = m_bus.wdata;
  assign m_wstrb  = m_bus.wstrb;
  assign m_cached = m_bus.cached;

  assign accept    = m_req & m_addr_ok;
  assign i_addr_ok = accept & (grant == OWN_INST);
  assign d_addr_ok = accept & (grant == OWN_DATA);

  assign pop       = m_data_ok & ~empty;
  assign i_data_ok = pop & (head == OWN_INST);
  assign d_data_ok = pop & (head == OWN_DATA);
  assign i_rdata   = i_data_ok ? m_rdata : i_rdata_q;
  assign d_rdata   = d_data_ok ? m_rdata : d_rdata_q;

  owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (grant),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock       <= 1'b0;
      lock_owner <= OWN_DATA;
      proto_err  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      lock       <= m_req & ~m_addr_ok;
      lock_owner <= grant;
      if ((lock & ~owner_req) | (m_data_ok & empty)) proto_err <= 1'b1;
      if (i_data_ok) i_rdata_q <= m_rdata;
      if (d_data_ok) d_rdata_q <= m_rdata;
    end
  end

`ifdef ARB_RR_FAIR_EN
  always_ff @(posedge clk) begin
    if (!rst)        rr_ptr <= OWN_DATA;
    else if (accept) rr_ptr <= other_owner(grant);
  end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized and directed bench for sram_bus_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned OUTSTANDING = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
`ifdef ARB_RR_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk, rst;
  logic i_req, i_wr, i_cached, i_addr_ok, i_data_ok;
  logic [1:0] i_size;
  logic [3:0] i_wstrb;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata, i_rdata;
  logic d_req, d_wr, d_cached, d_addr_ok, d_data_ok;
  logic [1:0] d_size;
  logic [3:0] d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic m_req, m_wr, m_cached, m_addr_ok, m_data_ok, proto_err;
  logic [1:0] m_size;
  logic [3:0] m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  sram_bus_arbiter #(.OUTSTANDING(OUTSTANDING), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_cached(i_cached), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_cached(d_cached), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_cached(m_cached), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          active;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        cached;
  } pend_t;

  pend_t ip, dp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: owner queue (0=inst, 1=data), lock, sticky error, fairness pointer, last rdata.
  bit          mdl_q[$];
  bit          mdl_lock;
  bit          mdl_owner;
  bit          mdl_err;
  bit          mdl_rr;
  logic [31:0] mdl_i_rd, mdl_d_rd;
  bit          i_rd_valid, d_rd_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    mdl_q.delete();
    mdl_lock   = 1'b0;
    mdl_owner  = 1'b1;
    mdl_err    = 1'b0;
    mdl_rr     = 1'b1;
    i_rd_valid = 1'b0;
    d_rd_valid = 1'b0;
  endtask

  function automatic pend_t rand_req(input bit act);
    pend_t p;
    p.active = act;
    p.wr     = 1'($urandom_range(0, 1));
    p.size   = 2'($urandom_range(0, 3));
    p.addr   = $urandom;
    p.wdata  = $urandom;
    p.wstrb  = 4'($urandom_range(0, 15));
    p.cached = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic drive_masters();
    i_req = ip.active; i_wr = ip.wr; i_size = ip.size; i_addr = ip.addr;
    i_wdata = ip.wdata; i_wstrb = ip.wstrb; i_cached = ip.cached;
    d_req = dp.active; d_wr = dp.wr; d_size = dp.size; d_addr = dp.addr;
    d_wdata = dp.wdata; d_wstrb = dp.wstrb; d_cached = dp.cached;
  endtask

  // Compare all outputs for the current (settled) cycle, then advance the model across the edge.
  task automatic eval_model(output bit acc_i, output bit acc_d);
    bit grant, any, mreq, acc, pop_ok, exp_i_dok, exp_d_dok, owner_has_req;
    owner_has_req = mdl_owner ? d_req : i_req;
    if (mdl_lock && owner_has_req) grant = mdl_owner;
    else if (d_req && i_req)       grant = FAIR ? mdl_rr : 1'b1;
    else if (d_req)                grant = 1'b1;
    else if (i_req)                grant = 1'b0;
    else                           grant = 1'b1;
    any  = i_req | d_req;
    mreq = any && (mdl_q.size() < OUTSTANDING);
    acc  = mreq && m_addr_ok;
    pop_ok    = m_data_ok && (mdl_q.size() > 0);
    exp_i_dok = pop_ok && (mdl_q[0] == 1'b0);
    exp_d_dok = pop_ok && (mdl_q[0] == 1'b1);

    check("m_req", m_req, mreq);
    check("i_addr_ok", i_addr_ok, acc && !grant);
    check("d_addr_ok", d_addr_ok, acc && grant);
    check("m_addr", m_addr, grant ? d_addr : i_addr);
    check("m_wdata", m_wdata, grant ? d_wdata : i_wdata);
    check("m_attr", {m_wr, m_size, m_wstrb, m_cached},
          grant ? {d_wr, d_size, d_wstrb, d_cached} : {i_wr, i_size, i_wstrb, i_cached});
    check("i_data_ok", i_data_ok, exp_i_dok);
    check("d_data_ok", d_data_ok, exp_d_dok);
    if (exp_i_dok) begin mdl_i_rd = m_rdata; i_rd_valid = 1'b1; end
    if (exp_d_dok) begin mdl_d_rd = m_rdata; d_rd_valid = 1'b1; end
    if (i_rd_valid) check("i_rdata", i_rdata, mdl_i_rd);
    if (d_rd_valid) check("d_rdata", d_rdata, mdl_d_rd);
    check("proto_err", proto_err, mdl_err);

    if ((mdl_lock && !owner_has_req) || (m_data_ok && mdl_q.size() == 0)) mdl_err = 1'b1;
    if (pop_ok) void'(mdl_q.pop_front());
    if (acc) begin
      mdl_q.push_back(grant);
      mdl_rr = !grant;
    end
    mdl_lock  = mreq && !m_addr_ok;
    mdl_owner = grant;
    acc_i = acc && !grant;
    acc_d = acc && grant;
  endtask

  // Called at posedge+4 with inputs settled; returns at the next posedge+1.
  task automatic tick();
    bit ai, ad;
    eval_model(ai, ad);
    if (ai) ip.active = 1'b0;
    if (ad) dp.active = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic slave(input bit aok, input bit dok, input logic [31:0] rd);
    m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ip = rand_req(1'b0);
    dp = rand_req(1'b0);
    drive_masters();
    slave(1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    reset_model();
    #3;
    check("rst_m_req", m_req, 1'b0);
    check("rst_addr_ok", {i_addr_ok, d_addr_ok}, 2'b00);
    check("rst_data_ok", {i_data_ok, d_data_ok}, 2'b00);
    check("rst_proto_err", proto_err, 1'b0);
    tick();
  endtask

  task automatic drain();
    ip.active = 1'b0; dp.active = 1'b0;
    for (int k = 0; k < 2 * OUTSTANDING + 2 && mdl_q.size() > 0; k++) begin
      drive_masters();
      slave(1'b0, 1'b1, $urandom);
      #3;
      tick();
    end
    check("drain_empty", 32'(mdl_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();

    // Contention straight after reset: data first, inst next cycle, data returns later.
    ip = rand_req(1'b1); ip.addr = 32'hBFC0_0000;
    dp = rand_req(1'b1); dp.addr = 32'h0000_1000;
    drive_masters(); slave(1'b1, 1'b0, '0); #3;
    check("cont_m_addr", m_addr, 32'h0000_1000);
    check("cont_d_aok", d_addr_ok, 1'b1);
    check("cont_i_aok", i_addr_ok, 1'b0);
    tick();
    drive_masters(); slave(1'b1, 1'b0, '0); #3;
    check("cont_i_next", i_addr_ok, 1'b1);
    tick();
    drive_masters(); slave(1'b0, 1'b1, 32'hAAAA_5555); #3;
    check("cont_d_dok", d_data_ok, 1'b1);
    check("cont_d_rdata", d_rdata, 32'hAAAA_5555);
    tick();
    drain();

    // Ordering and full: inst then data accepted, new inst request blocked until a pop clears space.
    ip = rand_req(1'b1); drive_masters(); slave(1'b1, 1'b0, '0); #3; tick();
    dp = rand_req(1'b1); drive_masters(); slave(1'b1, 1'b0, '0); #3; tick();
    ip = rand_req(1'b1); drive_masters(); slave(1'b1, 1'b0, '0); #3;
    check("full_m_req", m_req, 1'b0);
    tick();
    drive_masters(); slave(1'b1, 1'b1, 32'h11); #3;
    check("full_pop_m_req", m_req, 1'b0);
    check("ord_i_dok", i_data_ok, 1'b1);
    check("ord_i_rdata", i_rdata, 32'h11);
    tick();
    drive_masters(); slave(1'b1, 1'b1, 32'h22); #3;
    check("full_resume", m_req, 1'b1);
    check("ord_d_dok", d_data_ok, 1'b1);
    check("ord_d_rdata", d_rdata, 32'h22);
    tick();
    drain();

    // Lock: inst waits 3 cycles for addr_ok, data request arrives meanwhile.
    ip = rand_req(1'b1); ip.addr = 32'hBFC0_0000; dp = rand_req(1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) dp = rand_req(1'b1);
      drive_masters(); slave(c == 3, 1'b0, '0); #3;
      check("lock_m_addr", m_addr, 32'hBFC0_0000);
      tick();
    end
    drain();

    // Random traffic with well-behaved masters and slave.
    for (int n = 0; n < 3000; n++) begin
      if (!ip.active && $urandom_range(0, 99) < 60) ip = rand_req(1'b1);
      if (!dp.active && $urandom_range(0, 99) < 60) dp = rand_req(1'b1);
      drive_masters();
      slave(1'($urandom_range(0, 1)), (mdl_q.size() > 0) && ($urandom_range(0, 99) < 45), $urandom);
      #3;
      tick();
    end
    drain();

    // Data return with nothing outstanding.
    drive_masters(); slave(1'b0, 1'b1, 32'hDEAD_BEEF); #3;
    check("err_no_dok", {i_data_ok, d_data_ok}, 2'b00);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_masters(); slave(1'b0, 1'b0, '0); #3;
      check("err_sticky", proto_err, 1'b1);
      tick();
    end
    do_reset();

    // Locked master dropping its request.
    dp = rand_req(1'b1); drive_masters(); slave(1'b0, 1'b0, '0); #3; tick();
    dp.active = 1'b0; drive_masters(); slave(1'b0, 1'b0, '0); #3; tick();
    drive_masters(); #3;
    check("drop_err", proto_err, 1'b1);
    tick();
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
